// File: rtl/twiddle_rot_inv_w8_pipe_32b.sv
// twiddle_rot_inv_w8_pipe_32b: rotates a complex sample by W8^-k through a 3-stage valid/ready pipeline.
// Ports: clk, rst_n (async, active-low).
//   Input side:  in_valid_i, in_ready_o, in_data_i {re[31:16], im[15:0]}, in_k_i, in_last_i.
//   Output side: out_valid_o, out_ready_i, out_data_o {re, im}, out_last_o.
module twiddle_rot_inv_w8_pipe_32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic [2:0]  in_k_i,
    input  logic        in_last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_last_o
);
    localparam logic signed [32:0] C_HALFSQRT2 = 33'sd23170;

    logic               v1_q, v2_q, v3_q, ld1, ld2, ld3;
    logic signed [15:0] a_q, b_q;
    logic [2:0]         k1_q;
    logic               l1_q, l2_q, l3_q, odd2_q;
    logic signed [16:0] ae, be, re_d, im_d, re2_q, im2_q;
    logic signed [32:0] re_w, im_w, re_s, im_s;
    logic [15:0]        re3_d, im3_d, re3_q, im3_q;

    function automatic logic [15:0] sat(input logic signed [32:0] x);
        return (x > 33'sd32767) ? 16'h7FFF : (x < -33'sd32768) ? 16'h8000 : x[15:0];
    endfunction

    // A stage loads when empty or when the stage after it moves on this cycle.
    assign ld3        = !v3_q || out_ready_i;
    assign ld2        = !v2_q || ld3;
    assign ld1        = !v1_q || ld2;
    assign in_ready_o = ld1;

    assign ae = {a_q[15], a_q};
    assign be = {b_q[15], b_q};

    // Pre-terms are 17 bits wide; only -a-b with a=b=-32768 exceeds that range and wraps.
    always_comb begin
        re_d = ae;
        im_d = be;
        case (k1_q)
            3'd1: begin re_d = ae - be;  im_d = ae + be;  end
            3'd2: begin re_d = -be;      im_d = ae;       end
            3'd3: begin re_d = -ae - be; im_d = ae - be;  end
            3'd4: begin re_d = -ae;      im_d = -be;      end
            3'd5: begin re_d = be - ae;  im_d = -ae - be; end
            3'd6: begin re_d = be;       im_d = -ae;      end
            3'd7: begin re_d = ae + be;  im_d = be - ae;  end
            default: ;
        endcase
    end

    assign re_w  = {{16{re2_q[16]}}, re2_q};
    assign im_w  = {{16{im2_q[16]}}, im2_q};
    // Odd k carries a 1/sqrt2 factor; the arithmetic shift floors toward -inf.
    assign re_s  = odd2_q ? (re_w * C_HALFSQRT2) >>> 15 : re_w;
    assign im_s  = odd2_q ? (im_w * C_HALFSQRT2) >>> 15 : im_w;
    assign re3_d = sat(re_s);
    assign im3_d = sat(im_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            k1_q   <= '0;
            l1_q   <= 1'b0;
            re2_q  <= '0;
            im2_q  <= '0;
            odd2_q <= 1'b0;
            l2_q   <= 1'b0;
            re3_q  <= '0;
            im3_q  <= '0;
            l3_q   <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid_i;
                if (in_valid_i) begin
                    a_q  <= in_data_i[31:16];
                    b_q  <= in_data_i[15:0];
                    k1_q <= in_k_i;
                    l1_q <= in_last_i;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    re2_q  <= re_d;
                    im2_q  <= im_d;
                    odd2_q <= k1_q[0];
                    l2_q   <= l1_q;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    re3_q <= re3_d;
                    im3_q <= im3_d;
                    l3_q  <= l2_q;
                end
            end
        end
    end

    assign out_valid_o = v3_q;
    assign out_data_o  = {re3_q, im3_q};
    assign out_last_o  = l3_q;
endmodule
